// File: rtl/gate_pkg.sv
// Shared opcode definitions for the gate unit pipeline.
package gate_pkg;

    localparam int OP_W = 3;

    // Bitwise operation encoding. Each operation is applied across the full operand width.
    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
    localparam logic [OP_W-1:0] OP_NOTB = 3'd7;

endpackage

// File: rtl/gate_func.sv
// Combinational bitwise operation select: f = op(x, y).
module gate_func
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] f
);

    // Decode the opcode into one bitwise function of x and y.
    always_comb begin
        f = '0;
        case (op)
            OP_AND:  f = x & y;
            OP_OR:   f = x | y;
            OP_XOR:  f = x ^ y;
            OP_XNOR: f = ~(x ^ y);
            OP_NAND: f = ~(x & y);
            OP_NOR:  f = ~(x | y);
            OP_NOTA: f = ~x;
            OP_NOTB: f = ~y;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/gate_unit_pipe.sv
// Single-stage registered bitwise ALU with an accumulator, result flags and a
// saturating count of completed output handshakes.
module gate_unit_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             accept;
    logic             out_hs;
    logic [WIDTH-1:0] first_op;
    logic [WIDTH-1:0] func_out;

    // The output register may be overwritten whenever it is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    // A clear that arrives with an operand forces the first operand to zero, even when the accumulator is selected.
    assign first_op = acc_clr ? '0 : (acc_en ? acc_q : a);

    gate_func #(.WIDTH(WIDTH)) u_func (
        .op (op),
        .x  (first_op),
        .y  (b),
        .f  (func_out)
    );

    // Next-state for the output stage, accumulator and handshake counter.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
        acc_d       = acc_q;
        op_count_d  = op_count_q;

        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = func_out;
            zero_d      = (func_out == '0);
            ones_d      = (func_out == {WIDTH{1'b1}});
            parity_d    = ^func_out;
            acc_d       = func_out;
        end else begin
            if (out_hs)  out_valid_d = 1'b0;
            if (acc_clr) acc_d       = '0;
        end

        if (out_hs && (op_count_q != CNT_MAX))
            op_count_d = op_count_q + 1'b1;
    end

    // State register with synchronous reset; zero flag resets high to match the cleared result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            acc_q       <= '0;
            op_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            acc_q       <= acc_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign parity    = parity_q;
    assign op_count  = op_count_q;

endmodule

// File: doc/gate_unit_pipe.md
GATE_UNIT_PIPE -- requirements
Module: gate_unit_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, operand/result width in bits (1..64).
REQ-002 The block SHALL expose parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  operand/opcode presented.
REQ-006 Port in_ready  output  1  block can accept operands this cycle.
REQ-007 Port op  input  3  operation select (encoding REQ-014).
REQ-008 Port acc_en  input  1  use accumulator instead of a as first operand.
REQ-009 Port acc_clr  input  1  clear accumulator.
REQ-010 Port a, b  input  WIDTH each  operands.
REQ-011 Port out_valid  output  1  result held and valid.
REQ-012 Port out_ready  input  1  consumer takes result this cycle.
REQ-013 Ports result  output  WIDTH; zero, ones, parity  output  1 each; op_count  output  CNT_W.

Function
REQ-014 op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT first operand, 7 NOT b; applied bitwise across WIDTH.
REQ-015 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, single-register output stage).
REQ-016 First operand SHALL be acc when acc_en=1, else a; if acc_clr=1 in an accept cycle, first operand SHALL be 0 regardless of acc_en.
REQ-017 On accept, result SHALL be registered the next edge; latency exactly 1 cycle; out_valid SHALL assert that edge.
REQ-018 zero=(result==0), ones=(result==all ones), parity=XOR-reduce(result); all three SHALL be registered with result.
REQ-019 result and flags SHALL hold stable while out_valid && !out_ready.
REQ-020 out_valid SHALL drop the edge after out_valid && out_ready unless a new accept occurs that same cycle, in which case it SHALL stay high with the new result (back-to-back, full throughput).
REQ-021 On every accept, acc SHALL load the new result.
REQ-022 acc_clr=1 without accept SHALL set acc=0; accept takes precedence over clear for the acc update (acc = new result).
REQ-023 op_count SHALL increment by 1 on every output handshake (out_valid && out_ready) and SHALL saturate at 2^CNT_W-1.
REQ-024 Inputs other than acc_clr SHALL be ignored when no accept occurs.

Reset
REQ-025 While rst=1 at a rising edge: out_valid=0, result=0, zero=1, ones=0, parity=0, acc=0, op_count=0.
REQ-026 Reset mid-operation SHALL discard any held result without handshake; in_ready SHALL be 1 the cycle after reset deasserts.

Structure
REQ-027 Opcode constants (OP_AND..OP_NOTB) and op width SHALL live in shared package gate_pkg.
REQ-028 Bitwise operation select SHALL be a combinational sub-module gate_func (inputs op, x, y; output f; parameter WIDTH).
REQ-029 Top level SHALL contain only the output register stage, accumulator, flags and counter.

Verification
REQ-030 WIDTH=8: a=0xF0,b=0x3C, op 0..7 consecutive with out_ready=1 -> results 0x30,0xFC,0xCC,0x33,0xCF,0x03,0x0F,0xC3 on 8 consecutive cycles, op_count=8.
REQ-031 Backpressure: accept op=XOR a=0xAA b=0x55, hold out_ready=0 for 3 cycles -> result=0xFF, ones=1, in_ready=0, result stable; then out_ready=1 -> out_valid drops next cycle, op_count=1.
REQ-032 Accumulate: acc_clr=1 with op=OR b=0x01, then acc_en=1 op=OR b=0x02, then b=0x04 -> results 0x01,0x03,0x07.
REQ-033 Flags: op=AND a=0x00 -> zero=1, parity=0; op=XOR a=0x07 b=0x00 -> parity=1, zero=0.
REQ-034 Saturation: CNT_W=2, 5 handshakes -> op_count sequence 1,2,3,3,3.
REQ-035 Reset mid-stall: result held with out_ready=0, assert rst one cycle -> out_valid=0, result=0, zero=1, acc=0, op_count=0, in_ready=1 next cycle.
